img_tx_sequencer: RTL and testbench

- Sequences a full-frame transfer from the 24-bit pixel memory through the grayscale filter to the UART transmitter.
- Issues memory addresses and captures each filtered gray byte, then writes that byte REPEAT times (R, G, B) into the UART TX FIFO, honouring tx_full.
- Replaces the free-running address counter and the permanently asserted write strobe with a start/abort-controlled, flow-controlled transfer.

---
 rtl/img_tx_sequencer_pkg.sv | 24 ++
 rtl/img_tx_sequencer.sv | 109 ++++++++++
 tb/tb_img_tx_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_tx_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : img_tx_sequencer_pkg
//  Description : Shared state encoding and default frame geometry for the
//                image transmit sequencer and its bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package img_tx_sequencer_pkg;

    // FSM state encoding (3 bits)
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] NEXT  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    // Default frame geometry
    localparam int DEF_ADDR_BITS   = 13;
    localparam int DEF_PIXEL_COUNT = 6767;
    localparam int DEF_REPEAT      = 3;

endpackage : img_tx_sequencer_pkg
`default_nettype wire

// File: rtl/img_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : img_tx_sequencer
//  Description : Walks the pixel memory one address at a time, captures the
//                filtered gray byte and writes it REPEAT times into the UART
//                TX FIFO, stalling on tx_full. Start/abort controlled.
//  Revision    : 1.0 - initial release
// ============================================================================
module img_tx_sequencer
    import img_tx_sequencer_pkg::*;
#(
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int PIXEL_COUNT = DEF_PIXEL_COUNT,
    parameter int REPEAT      = DEF_REPEAT
) (
    input  logic                 clk,
    input  logic                 reset,      // active-low, asynchronous
    input  logic                 start,
    input  logic                 abort,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           gray,
    input  logic                 tx_full,
    output logic [7:0]           w_data,
    output logic                 wr_uart,
    output logic                 busy,
    output logic                 done
);

    localparam int                   c_rep_bits  = $clog2(REPEAT + 1);
    localparam logic [ADDR_BITS-1:0] c_last_addr = ADDR_BITS'(PIXEL_COUNT - 1);
    localparam logic [c_rep_bits-1:0] c_last_rep = c_rep_bits'(REPEAT - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [7:0]            r_pix;
    logic [c_rep_bits-1:0] r_rep_cnt;

    // Next-state decode; abort overrides everything, including start.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_next_state = FETCH;
                FETCH:   w_next_state = LATCH;
                LATCH:   w_next_state = SEND;
                SEND:    if (!tx_full && (r_rep_cnt == c_last_rep)) w_next_state = NEXT;
                NEXT:    w_next_state = (mem_addr == c_last_addr) ? DONE : FETCH;
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Address, pixel capture, repeat counter and registered UART/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            r_pix     <= '0;
            r_rep_cnt <= '0;
            w_data    <= '0;
            wr_uart   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wr_uart <= 1'b0;
            done    <= 1'b0;
            busy    <= (w_next_state != IDLE);
            if (abort) begin
                mem_addr <= '0;
            end else begin
                case (r_state)
                    IDLE: mem_addr <= '0;
                    LATCH: begin
                        r_pix     <= gray;
                        r_rep_cnt <= '0;
                    end
                    // A write only issues when the FIFO has room, so a stalled
                    // byte is simply retried on a later cycle.
                    SEND: begin
                        if (!tx_full) begin
                            wr_uart   <= 1'b1;
                            w_data    <= r_pix;
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        end
                    end
                    // Address only advances below the last pixel; it never wraps.
                    NEXT: begin
                        if (mem_addr != c_last_addr) mem_addr <= mem_addr + 1'b1;
                    end
                    DONE: begin
                        done     <= 1'b1;
                        mem_addr <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule : img_tx_sequencer
`default_nettype wire

// File: tb/tb_img_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_img_tx_sequencer
//  Description : Directed self-checking bench for img_tx_sequencer. A short
//                4-pixel instance covers the frame scenarios; an 8-pixel
//                instance covers reset in the middle of pixel 5.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_img_tx_sequencer;
    import img_tx_sequencer_pkg::*;

    localparam int ADDR_BITS = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4-pixel frame
    logic                 rst_a_n, start_a, abort_a, tx_full_a;
    logic [7:0]           gray_a, w_data_a;
    logic [ADDR_BITS-1:0] mem_addr_a;
    logic                 wr_uart_a, busy_a, done_a;

    // Instance B: 8-pixel frame
    logic                 rst_b_n, start_b, abort_b, tx_full_b;
    logic [7:0]           gray_b, w_data_b;
    logic [ADDR_BITS-1:0] mem_addr_b;
    logic                 wr_uart_b, busy_b, done_b;

    img_tx_sequencer #(.ADDR_BITS(ADDR_BITS), .PIXEL_COUNT(4), .REPEAT(DEF_REPEAT)) u_dut (
        .clk(clk), .reset(rst_a_n), .start(start_a), .abort(abort_a),
        .mem_addr(mem_addr_a), .gray(gray_a), .tx_full(tx_full_a),
        .w_data(w_data_a), .wr_uart(wr_uart_a), .busy(busy_a), .done(done_a)
    );

    img_tx_sequencer #(.ADDR_BITS(ADDR_BITS), .PIXEL_COUNT(8), .REPEAT(DEF_REPEAT)) u_dut_long (
        .clk(clk), .reset(rst_b_n), .start(start_b), .abort(abort_b),
        .mem_addr(mem_addr_b), .gray(gray_b), .tx_full(tx_full_b),
        .w_data(w_data_b), .wr_uart(wr_uart_b), .busy(busy_b), .done(done_b)
    );

    // Synchronous-read pixel memory + filter model: gray for address a is 0x10*(a+1)
    logic [7:0] pix_mem [0:7];
    always @(posedge clk) begin
        gray_a <= pix_mem[mem_addr_a[2:0]];
        gray_b <= pix_mem[mem_addr_b[2:0]];
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Observation of instance A writes/done and instance B write count
    logic [7:0] wr_log[$];
    int         done_cnt  = 0;
    int         done_cyc  = -1;
    int         cyc       = 0;
    int         viol      = 0;
    int         b_wr_cnt  = 0;
    logic       txf_q     = 1'b0;

    always @(posedge clk) txf_q <= tx_full_a;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_uart_a) begin
            wr_log.push_back(w_data_a);
            if (txf_q) viol = viol + 1;
        end
        if (done_a) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (wr_uart_b) b_wr_cnt = b_wr_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        tests_run++;
        if (done_cnt == d0) begin
            tests_failed++;
            $display("FAIL %s_done_timeout: done not seen after %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; tx_full_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; tx_full_b = 1'b0;
        tick(); tick();
        tests_run++; if (mem_addr_a !== '0)  begin tests_failed++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr_a); end
        tests_run++; if (w_data_a !== 8'h00) begin tests_failed++; $display("FAIL reset_w_data: got %0h expected 0", w_data_a); end
        tests_run++; if (wr_uart_a !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_uart: got %0b expected 0", wr_uart_a); end
        tests_run++; if (busy_a !== 1'b0)    begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", busy_a); end
        tests_run++; if (done_a !== 1'b0)    begin tests_failed++; $display("FAIL reset_done: got %0b expected 0", done_a); end
        tests_run++; if (busy_b !== 1'b0)    begin tests_failed++; $display("FAIL reset_busy_long: got %0b expected 0", busy_b); end
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_frame();
        int d0;
        int fb;
        wr_log.delete();
        d0 = done_cnt;
        pulse_start_a();
        fb = cyc;
        tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL frame_busy_rise: got %0b expected 1", busy_a); end
        wait_done(200, "frame");
        tests_run++; if (done_cyc - fb != 25) begin tests_failed++; $display("FAIL frame_latency: got %0d expected 25", done_cyc - fb); end
        tests_run++; if (wr_log.size() != 12) begin tests_failed++; $display("FAIL frame_write_count: got %0d expected 12", wr_log.size()); end
        for (int i = 0; i < 12 && i < wr_log.size(); i++) begin
            tests_run++;
            if (wr_log[i] !== 8'(16 * (i / 3 + 1))) begin
                tests_failed++;
                $display("FAIL frame_byte[%0d]: got %0h expected %0h", i, wr_log[i], 8'(16 * (i / 3 + 1)));
            end
        end
        repeat (5) tick();
        tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL frame_done_pulses: got %0d expected 1", done_cnt - d0); end
        tests_run++; if (busy_a !== 1'b0)    begin tests_failed++; $display("FAIL frame_busy_end: got %0b expected 0", busy_a); end
        tests_run++; if (mem_addr_a !== '0)  begin tests_failed++; $display("FAIL frame_addr_end: got %0h expected 0", mem_addr_a); end
    endtask

    task automatic test_backpressure();
        int n;
        int n10;
        wr_log.delete();
        viol = 0;
        pulse_start_a();
        n = 0;
        while (wr_log.size() < 2 && n < 50) begin tick(); n++; end
        tests_run++; if (wr_log.size() != 2) begin tests_failed++; $display("FAIL bp_second_write: got %0d writes expected 2", wr_log.size()); end
        tx_full_a = 1'b1;
        repeat (7) tick();
        tests_run++; if (wr_log.size() != 2) begin tests_failed++; $display("FAIL bp_stall: got %0d writes expected 2", wr_log.size()); end
        tx_full_a = 1'b0;
        wait_done(200, "bp");
        tests_run++; if (wr_log.size() != 12) begin tests_failed++; $display("FAIL bp_write_count: got %0d expected 12", wr_log.size()); end
        n10 = 0;
        foreach (wr_log[i]) if (wr_log[i] == 8'h10) n10++;
        tests_run++; if (n10 != 3) begin tests_failed++; $display("FAIL bp_pixel0_count: got %0d expected 3", n10); end
        for (int i = 0; i < 12 && i < wr_log.size(); i++) begin
            tests_run++;
            if (wr_log[i] !== 8'(16 * (i / 3 + 1))) begin
                tests_failed++;
                $display("FAIL bp_byte[%0d]: got %0h expected %0h", i, wr_log[i], 8'(16 * (i / 3 + 1)));
            end
        end
        tests_run++; if (viol != 0) begin tests_failed++; $display("FAIL bp_write_while_full: got %0d expected 0", viol); end
        repeat (3) tick();
    endtask

    task automatic test_start_while_busy();
        int d0;
        int n;
        wr_log.delete();
        d0 = done_cnt;
        pulse_start_a();
        n = 0;
        while (mem_addr_a != 2 && n < 50) begin tick(); n++; end
        tests_run++; if (mem_addr_a !== 13'd2) begin tests_failed++; $display("FAIL swb_reach_pixel2: got %0h expected 2", mem_addr_a); end
        pulse_start_a();
        wait_done(200, "swb");
        tests_run++; if (wr_log.size() != 12) begin tests_failed++; $display("FAIL swb_write_count: got %0d expected 12", wr_log.size()); end
        repeat (20) tick();
        tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL swb_done_pulses: got %0d expected 1", done_cnt - d0); end
        tests_run++; if (busy_a !== 1'b0)    begin tests_failed++; $display("FAIL swb_not_queued: busy got %0b expected 0", busy_a); end
    endtask

    task automatic test_abort();
        int d0;
        int n;
        wr_log.delete();
        d0 = done_cnt;
        pulse_start_a();
        n = 0;
        while (wr_log.size() < 7 && n < 60) begin tick(); n++; end
        tests_run++; if (wr_log.size() != 7) begin tests_failed++; $display("FAIL abort_reach: got %0d writes expected 7", wr_log.size()); end
        tests_run++; if (mem_addr_a !== 13'd2) begin tests_failed++; $display("FAIL abort_addr_before: got %0h expected 2", mem_addr_a); end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        tests_run++; if (busy_a !== 1'b0)    begin tests_failed++; $display("FAIL abort_busy: got %0b expected 0", busy_a); end
        tests_run++; if (wr_uart_a !== 1'b0) begin tests_failed++; $display("FAIL abort_wr_uart: got %0b expected 0", wr_uart_a); end
        tests_run++; if (mem_addr_a !== '0)  begin tests_failed++; $display("FAIL abort_addr: got %0h expected 0", mem_addr_a); end
        repeat (30) tick();
        tests_run++; if (wr_log.size() != 7) begin tests_failed++; $display("FAIL abort_no_writes: got %0d expected 7", wr_log.size()); end
        tests_run++; if (done_cnt != d0)     begin tests_failed++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - d0); end
        wr_log.delete();
        pulse_start_a();
        n = 0;
        while (wr_log.size() < 1 && n < 20) begin tick(); n++; end
        tests_run++;
        if (wr_log.size() < 1 || wr_log[0] !== 8'h10) begin
            tests_failed++;
            $display("FAIL abort_restart_byte: got %0d writes first=%0h expected 0x10", wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 8'h00);
        end
        wait_done(200, "abort_restart");
        repeat (3) tick();
    endtask

    task automatic test_start_abort();
        wr_log.delete();
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        tests_run++; if (busy_a !== 1'b0)   begin tests_failed++; $display("FAIL sa_busy: got %0b expected 0", busy_a); end
        tests_run++; if (mem_addr_a !== '0) begin tests_failed++; $display("FAIL sa_addr: got %0h expected 0", mem_addr_a); end
        repeat (10) tick();
        tests_run++; if (busy_a !== 1'b0)     begin tests_failed++; $display("FAIL sa_busy_later: got %0b expected 0", busy_a); end
        tests_run++; if (wr_log.size() != 0)  begin tests_failed++; $display("FAIL sa_no_writes: got %0d expected 0", wr_log.size()); end
    endtask

    task automatic test_reset_midframe();
        int n;
        int c0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        // Pixels 0..4 give 15 writes; the 16th is rep 0 of pixel 5.
        while (b_wr_cnt < 16 && n < 120) begin tick(); n++; end
        tests_run++; if (mem_addr_b !== 13'd5) begin tests_failed++; $display("FAIL rmf_reach_pixel5: got %0h expected 5", mem_addr_b); end
        rst_b_n = 1'b0;
        tick();
        tests_run++; if (wr_uart_b !== 1'b0) begin tests_failed++; $display("FAIL rmf_wr_uart: got %0b expected 0", wr_uart_b); end
        tests_run++; if (busy_b !== 1'b0)    begin tests_failed++; $display("FAIL rmf_busy: got %0b expected 0", busy_b); end
        tests_run++; if (mem_addr_b !== '0)  begin tests_failed++; $display("FAIL rmf_addr: got %0h expected 0", mem_addr_b); end
        c0 = b_wr_cnt;
        rst_b_n = 1'b1;
        repeat (20) tick();
        tests_run++; if (b_wr_cnt != c0)  begin tests_failed++; $display("FAIL rmf_no_writes: got %0d extra expected 0", b_wr_cnt - c0); end
        tests_run++; if (busy_b !== 1'b0) begin tests_failed++; $display("FAIL rmf_stays_idle: busy got %0b expected 0", busy_b); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) pix_mem[i] = 8'(16 * (i + 1));
        test_reset();
        test_frame();
        test_backpressure();
        test_start_while_busy();
        test_abort();
        test_start_abort();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_img_tx_sequencer
`default_nettype wire
